// File: rtl/fc_host_pkg.sv
// fc_host_pkg: shared types and defaults for the fc layer stream host.
//   state_t  : control FSM states (IDLE, SEND, RECV, DONE)
//   FC_WIDTH : default element width (signed two's complement)
package fc_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FC_WIDTH = 12;

endpackage

// File: rtl/fc_host_ram.sv
// fc_host_ram: synchronous RAM with write enable and a registered read.
//   SDP = 0 : single port, i_waddr addresses both the write and the read
//   SDP = 1 : simple dual port, i_raddr addresses the read independently
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write (and single-port read) address
//   i_wdata  in  write data
//   i_raddr  in  read address (dual-port mode only)
//   o_rdata  out registered read data, 1-cycle latency, read-before-write
module fc_host_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 24,
  parameter int SDP   = 0,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] w_raddr;

  assign w_raddr = (SDP != 0) ? i_raddr : i_waddr;
  assign o_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[w_raddr];
  end

endmodule

// File: rtl/fc_stream_host.sv
// fc_stream_host: stream-side host for an fc layer accelerator.
// Holds VECS input vectors of N elements, streams each vector to the
// accelerator one element per cycle, collects M results per vector into a
// result buffer, and pulses o_done at the end of a run.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_start             begin run (IDLE only)
//   i_ld_en/addr/data   source buffer write port (IDLE only)
//   o_x_valid/i_x_ready/o_x_data   element stream to accelerator
//   i_y_valid/o_y_ready/i_y_data   result stream from accelerator
//   i_rd_addr/o_rd_data result readback, 1-cycle latency, any state
//   o_busy, o_done, o_error        status (error is sticky timeout flag)
module fc_stream_host
  import fc_host_pkg::*;
#(
  parameter int WIDTH   = FC_WIDTH,
  parameter int N       = 6,
  parameter int M       = 6,
  parameter int VECS    = 4,
  parameter int TIMEOUT = 1024,
  parameter int SAW     = $clog2(VECS*N),
  parameter int RAW     = $clog2(VECS*M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_ld_en,
  input  logic [SAW-1:0]   i_ld_addr,
  input  logic [WIDTH-1:0] i_ld_data,
  output logic             o_x_valid,
  input  logic             i_x_ready,
  output logic [WIDTH-1:0] o_x_data,
  input  logic             i_y_valid,
  output logic             o_y_ready,
  input  logic [WIDTH-1:0] i_y_data,
  input  logic [RAW-1:0]   i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error
);

  localparam int EW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = (M > 1) ? $clog2(M) : 1;
  localparam int VW = (VECS > 1) ? $clog2(VECS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        r_state, w_state_nxt;
  logic [EW-1:0] r_elem,  w_elem_nxt;
  logic [OW-1:0] r_out,   w_out_nxt;
  logic [VW-1:0] r_vec,   w_vec_nxt;
  logic [TW-1:0] r_tmo,   w_tmo_nxt;
  logic          r_err,   w_err_nxt;

  logic           w_fire;
  logic           w_src_we;
  logic [SAW-1:0] w_src_addr;
  logic [SAW-1:0] w_src_port;
  logic           w_res_we;
  logic [RAW-1:0] w_res_waddr;

  assign w_fire = o_x_valid && i_x_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_elem  <= '0;
      r_out   <= '0;
      r_vec   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_out   <= w_out_nxt;
      r_vec   <= w_vec_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_out_nxt   = r_out;
    w_vec_nxt   = r_vec;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err;
    o_x_valid   = 1'b0;
    o_y_ready   = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = SEND;
          w_elem_nxt  = '0;
          w_out_nxt   = '0;
          w_vec_nxt   = '0;
          w_tmo_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      SEND: begin
        o_x_valid = 1'b1;
        if (i_x_ready) begin
          if (r_elem == EW'(N-1)) begin
            w_elem_nxt  = '0;
            w_tmo_nxt   = '0;
            w_state_nxt = RECV;
          end else begin
            w_elem_nxt = r_elem + 1'b1;
          end
        end
      end
      RECV: begin
        o_y_ready = 1'b1;
        if (i_y_valid) begin
          w_tmo_nxt = '0;
          if (r_out == OW'(M-1)) begin
            w_out_nxt = '0;
            if (r_vec == VW'(VECS-1)) begin
              w_state_nxt = DONE;
            end else begin
              w_vec_nxt   = r_vec + 1'b1;
              w_state_nxt = SEND;
            end
          end else begin
            w_out_nxt = r_out + 1'b1;
          end
        end else if (r_tmo == TW'(TIMEOUT-1)) begin
          // TIMEOUT consecutive cycles without a result: abandon the run
          w_tmo_nxt   = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The source read address tracks the next-cycle indices, so the RAM output
  // register presents the element that will be on the bus next cycle. A
  // stalled element re-reads the same address, which keeps x_data stable;
  // start and the last result of a vector naturally select the next base.
  assign w_src_addr = SAW'(32'(w_vec_nxt) * 32'(N) + 32'(w_elem_nxt));

  // The source buffer is single-ported: a load borrows the port in IDLE.
  // A load in the same cycle as start is dropped so the port can fetch
  // element 0 of the run.
  assign w_src_we   = (r_state == IDLE) && i_ld_en && !i_start;
  assign w_src_port = w_src_we ? i_ld_addr : w_src_addr;

  fc_host_ram #(.DW(WIDTH), .DEPTH(VECS*N), .SDP(0), .AW(SAW)) u_src_ram (
    .clk     (clk),
    .i_we    (w_src_we),
    .i_waddr (w_src_port),
    .i_wdata (i_ld_data),
    .i_raddr (w_src_port),
    .o_rdata (o_x_data)
  );

  assign w_res_we    = (r_state == RECV) && i_y_valid;
  assign w_res_waddr = RAW'(32'(r_vec) * 32'(M) + 32'(r_out));

  fc_host_ram #(.DW(WIDTH), .DEPTH(VECS*M), .SDP(1), .AW(RAW)) u_res_ram (
    .clk     (clk),
    .i_we    (w_res_we),
    .i_waddr (w_res_waddr),
    .i_wdata (i_y_data),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_busy  = (r_state != IDLE);
  assign o_error = r_err;

endmodule

// File: tb/tb_fc_stream_host.sv
// Directed bench for fc_stream_host: inputs driven and outputs sampled on
// the falling edge; expected data computed from the load pattern.
module tb_fc_stream_host;

  localparam int WIDTH   = 12;
  localparam int N       = 6;
  localparam int M       = 6;
  localparam int VECS    = 4;
  localparam int TIMEOUT = 1024;
  localparam int SAW     = $clog2(VECS*N);
  localparam int RAW     = $clog2(VECS*M);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             ld_en = 1'b0;
  logic [SAW-1:0]   ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;
  logic             x_valid;
  logic             x_ready = 1'b0;
  logic [WIDTH-1:0] x_data;
  logic             y_valid = 1'b0;
  logic             y_ready;
  logic [WIDTH-1:0] y_data = '0;
  logic [RAW-1:0]   rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic             busy, done, error;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fc_stream_host #(.WIDTH(WIDTH), .N(N), .M(M), .VECS(VECS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (start),
    .i_ld_en   (ld_en),
    .i_ld_addr (ld_addr),
    .i_ld_data (ld_data),
    .o_x_valid (x_valid),
    .i_x_ready (x_ready),
    .o_x_data  (x_data),
    .i_y_valid (y_valid),
    .o_y_ready (y_ready),
    .i_y_data  (y_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_busy    (busy),
    .o_done    (done),
    .o_error   (error)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int src_val(input int v, input int k);
    return (v + 1) * (k + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input bit hold);
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  task automatic rd_chk(input int addr, input int exp);
    rd_addr = RAW'(addr);
    step();
    chk($sformatf("rd_data[%0d]", addr), int'(rd_data), exp);
  endtask

  // Streams n_el elements of vector v; toggle drives x_ready 1,0,1,0...;
  // junk drives y_valid and source loads that must be ignored.
  task automatic send_vec(input int v, input int n_el, input bit toggle, input bit junk);
    int k = 0;
    int cyc = 0;
    bit rdy;
    while (k < n_el && cyc < 4*N) begin
      rdy = !toggle || (cyc % 2 == 0);
      x_ready = rdy;
      if (junk) begin
        y_valid = 1'b1;
        y_data  = 12'h7FF;
        ld_en   = 1'b1;
        ld_addr = SAW'((v*N + k + 1) % (VECS*N));
        ld_data = 12'hAAA;
        chk($sformatf("y_ready_in_send v%0d", v), int'(y_ready), 0);
      end
      chk($sformatf("x_valid v%0d k%0d", v, k), int'(x_valid), 1);
      chk($sformatf("x_data v%0d k%0d", v, k), int'(x_data), src_val(v, k));
      step();
      if (rdy) k++;
      cyc++;
    end
    x_ready = 1'b0;
    y_valid = 1'b0;
    ld_en   = 1'b0;
    chk($sformatf("send_count v%0d", v), k, n_el);
  endtask

  task automatic recv_vec(input int v, input int base);
    chk($sformatf("x_valid_recv v%0d", v), int'(x_valid), 0);
    for (int j = 0; j < M; j++) begin
      y_valid = 1'b1;
      y_data  = WIDTH'(base + 10*v + j);
      chk($sformatf("y_ready v%0d j%0d", v, j), int'(y_ready), 1);
      step();
    end
    y_valid = 1'b0;
  endtask

  task automatic end_of_run();
    chk("done_pulse", int'(done), 1);
    chk("busy_in_done", int'(busy), 1);
    step();
    chk("done_cleared", int'(done), 0);
    chk("busy_dropped", int'(busy), 0);
  endtask

  task automatic readback(input int base);
    for (int v = 0; v < VECS; v++)
      for (int j = 0; j < M; j++)
        rd_chk(v*M + j, base + 10*v + j);
  endtask

  // junk also holds start high for most of the run and checks, while each
  // vector waits in RECV, that slot v*M still holds the previous run's value.
  task automatic run_all(input int base, input bit toggle, input bit junk, input int prev);
    do_start(junk);
    for (int v = 0; v < VECS; v++) begin
      send_vec(v, N, toggle, junk);
      if (v == VECS-1) start = 1'b0;
      if (junk) rd_chk(v*M, prev + 10*v);
      recv_vec(v, base);
    end
    end_of_run();
  endtask

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x_valid", int'(x_valid), 0);
    chk("rst_y_ready", int'(y_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b0;

    for (int a = 0; a < VECS*N; a++) begin
      ld_en   = 1'b1;
      ld_addr = SAW'(a);
      ld_data = WIDTH'(src_val(a / N, a % N));
      step();
    end
    ld_en = 1'b0;

    // gap-free streaming, then stalls, then ignored traffic
    run_all(0, 1'b0, 1'b0, 0);
    readback(0);
    run_all(5, 1'b1, 1'b0, 0);
    readback(5);
    run_all(20, 1'b0, 1'b1, 5);
    readback(20);

    // responder silent in RECV
    do_start(1'b0);
    send_vec(0, N, 1'b0, 1'b0);
    cnt = 0;
    while (!done && cnt < TIMEOUT + 20) begin
      step();
      cnt++;
    end
    chk("timeout_cycles", cnt, TIMEOUT);
    chk("timeout_error", int'(error), 1);
    chk("timeout_done", int'(done), 1);
    step();
    chk("timeout_idle", int'(busy), 0);
    chk("error_sticky", int'(error), 1);
    do_start(1'b0);
    chk("error_cleared", int'(error), 0);

    // reset while element 3 of vector 1 is on the bus
    send_vec(0, N, 1'b0, 1'b0);
    recv_vec(0, 30);
    send_vec(1, 3, 1'b0, 1'b0);
    chk("pre_reset_x_data", int'(x_data), src_val(1, 3));
    reset = 1'b1;
    step();
    chk("midrst_x_valid", int'(x_valid), 0);
    chk("midrst_y_ready", int'(y_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    reset = 1'b0;
    run_all(40, 1'b0, 1'b0, 0);
    readback(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
